// File: rtl/sync_cnt_pkg.sv
// Shared constants and helpers for the synchronous down counter family.
package sync_cnt_pkg;

  localparam int CNT_WIDTH_DEF = 4;
  localparam bit CNT_RST_VAL   = 1'b0;

  // All-ones value for a counter of the given width (up to 32 bits).
  function automatic logic [31:0] cnt_all_ones(input int width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_down_counter_tff_ld.sv
// T flip-flop with synchronous reset and synchronous parallel load.
// Priority: rst > ld > t.
module tff_ld
  import sync_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q,
  output logic q1
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= CNT_RST_VAL;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign q1 = ~q;

endmodule

// File: rtl/sync_down_counter.sv
// Synchronous down counter from a chain of loadable T flops, with zero flag and
// cascadable borrow. Define DOWN_CNT_STOP_AT_ZERO_EN to saturate at zero.
module sync_down_counter
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow
);

  logic             cnt_en;
  logic [WIDTH-1:0] tog;

  assign zero = (q == '0);

`ifdef DOWN_CNT_STOP_AT_ZERO_EN
  // Gating every toggle with ~zero freezes the counter at 0.
  assign cnt_en = ~zero;
`else
  assign cnt_en = 1'b1;
`endif

  // Bit i toggles only when every lower bit is 0 (its inverted output is 1).
  assign tog[0] = t & cnt_en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tog
    assign tog[i] = tog[i-1] & q1[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_ld u_tff (
      .clk (clk),
      .rst (rst),
      .t   (tog[i]),
      .ld  (load),
      .d   (din[i]),
      .q   (q[i]),
      .q1  (q1[i])
    );
  end

  assign count  = q;
  assign borrow = t & ~load & zero;

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: directed steps push expected state,
// a negedge monitor pops and compares.
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       rst, t, load;
  logic [3:0] din, q, q1, count;
  logic       zero, borrow;

  logic       c_rst, c_t, c_load;
  logic [7:0] c_din;
  logic [3:0] lo_q, lo_q1, lo_cnt, hi_q, hi_q1, hi_cnt;
  logic       lo_zero, lo_borrow, hi_zero, hi_borrow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         casc;
    logic [7:0] q;
    logic       z;
    logic       b;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .t(t), .load(load), .din(din),
    .q(q), .q1(q1), .count(count), .zero(zero), .borrow(borrow)
  );

  sync_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(c_rst), .t(c_t), .load(c_load), .din(c_din[3:0]),
    .q(lo_q), .q1(lo_q1), .count(lo_cnt), .zero(lo_zero), .borrow(lo_borrow)
  );

  sync_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(c_rst), .t(lo_borrow), .load(c_load), .din(c_din[7:4]),
    .q(hi_q), .q1(hi_q1), .count(hi_cnt), .zero(hi_zero), .borrow(hi_borrow)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.casc) begin
        chk({e.nm, ".q"}, {hi_q, lo_q}, e.q);
        chk({e.nm, ".borrow"}, {7'd0, hi_borrow}, {7'd0, e.b});
      end else begin
        chk({e.nm, ".q"}, {4'd0, q}, e.q);
        chk({e.nm, ".q1"}, {4'd0, q1}, {4'd0, ~e.q[3:0]});
        chk({e.nm, ".count"}, {4'd0, count}, e.q);
        chk({e.nm, ".zero"}, {7'd0, zero}, {7'd0, e.z});
        chk({e.nm, ".borrow"}, {7'd0, borrow}, {7'd0, e.b});
      end
    end
  end

  // Apply inputs for one cycle and record the state expected during it.
  task automatic step(input logic r, input logic ld, input logic tt, input logic [3:0] d,
                      input logic [3:0] eq, input logic eb, input string nm);
    exp_t e;
    rst = r; load = ld; t = tt; din = d;
    e.casc = 1'b0; e.q = {4'd0, eq}; e.z = (eq == 4'd0); e.b = eb; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic cstep(input logic r, input logic ld, input logic tt, input logic [7:0] d,
                       input logic [7:0] eq, input logic eb, input string nm);
    exp_t e;
    c_rst = r; c_load = ld; c_t = tt; c_din = d;
    e.casc = 1'b1; e.q = eq; e.z = (eq == 8'd0); e.b = eb; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

`ifdef DOWN_CNT_STOP_AT_ZERO_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  initial begin
    rst = 1'b1; load = 1'b1; t = 1'b1; din = 4'hA;
    c_rst = 1'b1; c_load = 1'b0; c_t = 1'b0; c_din = 8'h00;
    @(posedge clk); #1;

    // Reset dominates load and t; borrow follows t once load drops.
    step(1, 1, 1, 4'hA, 4'h0, 0, "rst_ld");
    step(1, 0, 1, 4'hA, 4'h0, 1, "rst_t");
    step(0, 0, 0, 4'h0, 4'h0, 0, "rel0");
    step(0, 0, 0, 4'h0, 4'h0, 0, "hold0");

    // Full countdown 3,2,1,0 then wrap (or stick at zero).
    step(0, 1, 1, 4'h3, 4'h0, 0, "ld_at0");
    step(0, 0, 1, 4'h0, 4'h3, 0, "cd3");
    step(0, 0, 1, 4'h0, 4'h2, 0, "cd2");
    step(0, 0, 1, 4'h0, 4'h1, 0, "cd1");
    step(0, 0, 1, 4'h0, 4'h0, 1, "cd0");
    step(0, 0, 1, 4'h0, STOP ? 4'h0 : 4'hF, STOP ? 1'b1 : 1'b0, "cdwrap");
    step(0, 0, 0, 4'h0, STOP ? 4'h0 : 4'hE, 0, "cdhold");

    // Load has priority over count.
    step(0, 1, 0, 4'h7, STOP ? 4'h0 : 4'hE, 0, "ld7");
    step(0, 1, 1, 4'hC, 4'h7, 0, "ld_over_t");
    step(0, 0, 0, 4'h0, 4'hC, 0, "ldC");

    // Reset mid-count from 9.
    step(0, 1, 0, 4'h9, 4'hC, 0, "ld9");
    step(0, 0, 1, 4'h0, 4'h9, 0, "m9");
    step(0, 0, 1, 4'h0, 4'h8, 0, "m8");
    step(0, 0, 1, 4'h0, 4'h7, 0, "m7");
    step(0, 0, 1, 4'h0, 4'h6, 0, "m6");
    step(1, 0, 1, 4'h0, 4'h5, 0, "m5_rst");
    step(0, 0, 0, 4'h0, 4'h0, 0, "after_rst");
    step(0, 0, 0, 4'h0, 4'h0, 0, "after_rst2");

    // Saturation behaviour around zero, then reload from the end state.
    step(0, 1, 0, 4'h1, 4'h0, 0, "ld1");
    step(0, 0, 1, 4'h0, 4'h1, 0, "s1");
    step(0, 0, 1, 4'h0, 4'h0, 1, "s0");
    step(0, 0, 1, 4'h0, STOP ? 4'h0 : 4'hF, STOP ? 1'b1 : 1'b0, "s_next");
    step(0, 0, 1, 4'h0, STOP ? 4'h0 : 4'hE, STOP ? 1'b1 : 1'b0, "s_next2");
    step(0, 1, 1, 4'h2, STOP ? 4'h0 : 4'hD, 0, "ld2");
    step(0, 0, 0, 4'h0, 4'h2, 0, "q2");

    // Two-stage cascade forming an 8-bit down counter.
    cstep(1, 0, 0, 8'h00, 8'h00, 0, "c_rst");
    cstep(0, 1, 1, 8'h01, 8'h00, 0, "c_ld");
    cstep(0, 0, 1, 8'h00, 8'h01, 0, "c01");
    cstep(0, 0, 1, 8'h00, 8'h00, 1, "c00");
    cstep(0, 0, 1, 8'h00, STOP ? 8'h00 : 8'hFF, STOP ? 1'b1 : 1'b0, "cFF");
    cstep(0, 0, 0, 8'h00, STOP ? 8'h00 : 8'hFE, 0, "cFE");

    begin
      int wait_cyc;
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 20) begin
        @(posedge clk); #1;
        wait_cyc++;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous binary down counter built from a T flip-flop chain; the count-down counterpart of the team's 4-bit synchronous up counter.
- Toggle enables are formed by AND-ing the complemented lower bits, so bit i toggles when all lower bits are 0.
- Adds parallel load, a zero flag and a borrow output, so instances cascade into wider down counters or timeout/divider chains.

Parameters:
- WIDTH, 4, counter width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- t  input  1  count enable; decrement by 1 on a clock edge when high
- load  input  1  synchronous parallel load
- din  input  WIDTH  value loaded when load=1
- q  output  WIDTH  counter state
- q1  output  WIDTH  bitwise complement of q (per-flop inverted output)
- count  output  WIDTH  equal to q (alias for consumers)
- zero  output  1  combinational, high when q==0
- borrow  output  1  combinational, t & ~load & zero; cascade into next stage's t

Behaviour:
- One clock (clk); reset synchronous, active-high (rst), sampled only on the rising edge of clk.
- Priority at each rising edge: rst > load > t > hold.
- Reset:
  - q=0, q1=all ones, count=0, zero=1.
  - borrow follows t (t & ~load & zero, since zero=1 after reset).
  - rst asserted mid-count clears on the next edge regardless of load or t.
- Load:
  - q <= din on the edge; t is ignored that cycle.
  - borrow forced 0 while load=1.
- Count:
  - q <= (q - 1) mod 2^WIDTH, one-cycle latency; result visible after the edge.
  - Structure: toggle_0 = t; toggle_i = t & q1[0] & ... & q1[i-1].
  - Each bit is a T flop with synchronous reset and synchronous load.
- Wrap: with q=0 and t=1, next q = 2^WIDTH-1 (all ones); borrow=1 during that cycle.
- Hold: t=0, load=0 -> q unchanged; borrow=0.
- q1 is always ~q, including during reset and load cycles.
- No X propagation: din is sampled only when load=1.
- Cascade rule:
  - stage k+1 t = borrow of stage k.
  - Stage k+1 load/rst are tied to stage k's signals.
  - The chain forms a WIDTH*N down counter with no extra delay.

Optional Feature:
- Macro: DOWN_CNT_STOP_AT_ZERO_EN
- Defined:
  - Counter saturates at 0. With q=0 and t=1, q stays 0 (all toggle enables gated by ~zero).
  - borrow = t & ~load & zero still asserts every such cycle, giving a level "expired" indication.
  - load still reloads from 0.
- Undefined: wrap-around to all ones as above (default).

Decomposition:
- Package sync_cnt_pkg:
  - CNT_WIDTH_DEF = 4
  - CNT_RST_VAL = 0
  - helper function for the all-ones value of a given width
- One sub-module: tff_ld.
  - Ports: t, ld, d, clk, rst, q, q1.
  - Priority: sync reset > load > toggle.
  - Instantiated WIDTH times via generate.
  - The AND chain for toggle enables lives in the parent.

Test Plan:
- Reset: rst=1 for 2 cycles with t=1, load=1, din=4'hA -> q=0, q1=4'hF, zero=1 on each edge; after release with t=0 q holds at 0.
- Full countdown: load din=4'h3, then t=1 for 5 cycles -> q sequence 3,2,1,0,F; borrow=1 only in the cycle where q=0; zero=1 only in that same cycle.
- Load vs count priority: q=4'h7, load=1, t=1, din=4'hC -> next q=4'hC (not 6); borrow=0 in that cycle even when q=0 beforehand.
- Mid-operation reset: counting from 4'h9 with t=1, assert rst at q=4'h5 -> next q=0; no wrap to F; q1=4'hF.
- Cascade: two instances (8-bit total), low borrow drives high t, load 8'h01, t=1 for 3 cycles -> 8'h01, 8'h00, 8'hFF, 8'hFE; high-stage borrow=1 only while the total is 0.
- DOWN_CNT_STOP_AT_ZERO_EN build: load 4'h1, t=1 for 4 cycles -> q = 1,0,0,0; borrow=1 in every cycle where q=0 and t=1; then load 4'h2 -> q=2.
